// File: rtl/rs_enc_204_188.sv
// rtl/rs_enc_204_188.sv - systematic RS(204,188) encoder over GF(2^8), one byte per CE slot
module rs_enc_204_188 #(
   parameter int         N       = 204,
   parameter int         K       = 188,
   parameter logic [8:0] GF_POLY = 9'h11D,
   parameter int         FCR     = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       CE,
   input  logic [7:0] input_byte,
   output logic       Data_req,
   output logic [7:0] Out_byte,
   output logic       CEO,
   output logic       Valid_out,
   output logic       Parity_out
);

   localparam int NPAR = N - K;

   // Shift-and-add GF(2^8) multiply; with one operand constant it folds to an XOR tree.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {sh[6:0], 1'b0};
      end
      return acc;
   endfunction

   // alpha^e with alpha = 2
   function automatic logic [7:0] gf_alpha_pow(input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
      return r;
   endfunction

   // g(x) = prod (x - a^(FCR+i)); returns g0..g(NPAR-1) packed, g0 in the low byte.
   // The leading coefficient is 1 and is implicit in the LFSR.
   function automatic logic [NPAR*8-1:0] gen_poly();
      logic [NPAR:0][7:0]   c;
      logic [7:0]           r;
      logic [NPAR*8-1:0]    g;
      c    = '0;
      c[0] = 8'h01;
      for (int i = 0; i < NPAR; i++) begin
         r = gf_alpha_pow(FCR + i);
         for (int j = NPAR; j >= 1; j--) c[j] = c[j-1] ^ gf_mul(c[j], r);
         c[0] = gf_mul(c[0], r);
      end
      g = '0;
      for (int j = 0; j < NPAR; j++) g[8*j +: 8] = c[j];
      return g;
   endfunction

   localparam logic [NPAR*8-1:0] G = gen_poly();

   logic [7:0]            slot_q, slot_d;
   logic [NPAR-1:0][7:0]  p_q, p_d;
   logic [7:0]            out_byte_q, out_byte_d;
   logic                  ceo_q, ceo_d;
   logic                  valid_q, valid_d;
   logic                  parity_q, parity_d;
   logic                  msg_slot;
   logic [7:0]            fb;

   assign msg_slot = (slot_q < 8'(K));
   assign fb       = input_byte ^ p_q[NPAR-1];

   assign Data_req   = msg_slot;
   assign Out_byte   = out_byte_q;
   assign CEO        = ceo_q;
   assign Valid_out  = valid_q;
   assign Parity_out = parity_q;

   // Next state: message slots run the division LFSR, parity slots shift the remainder out.
   always_comb begin
      slot_d     = slot_q;
      p_d        = p_q;
      out_byte_d = out_byte_q;
      valid_d    = valid_q;
      parity_d   = parity_q;
      ceo_d      = 1'b0;
      if (CE) begin
         ceo_d   = 1'b1;
         valid_d = 1'b1;
         slot_d  = (slot_q == 8'(N - 1)) ? 8'd0 : slot_q + 8'd1;
         if (msg_slot) begin
            out_byte_d = input_byte;
            parity_d   = 1'b0;
            p_d[0]     = gf_mul(fb, G[7:0]);
            for (int i = 1; i < NPAR; i++) p_d[i] = p_q[i-1] ^ gf_mul(fb, G[8*i +: 8]);
         end else begin
            out_byte_d = p_q[NPAR-1];
            parity_d   = 1'b1;
            p_d[0]     = 8'h00;
            for (int i = 1; i < NPAR; i++) p_d[i] = p_q[i-1];
         end
      end
   end

   // State and registered outputs; async reset abandons any partial codeword.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q     <= 8'd0;
         p_q        <= '0;
         out_byte_q <= 8'h00;
         ceo_q      <= 1'b0;
         valid_q    <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         p_q        <= p_d;
         out_byte_q <= out_byte_d;
         ceo_q      <= ceo_d;
         valid_q    <= valid_d;
         parity_q   <= parity_d;
      end
   end

endmodule

// File: tb/tb_rs_enc_204_188.sv
// tb/tb_rs_enc_204_188.sv - scoreboard bench for rs_enc_204_188
module tb_rs_enc_204_188;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       CE = 1'b0;
   logic [7:0] input_byte = 8'h00;
   logic       Data_req;
   logic [7:0] Out_byte;
   logic       CEO;
   logic       Valid_out;
   logic       Parity_out;

   always #5 clk = ~clk;

   rs_enc_204_188 dut (
      .clk        (clk),
      .reset      (reset),
      .CE         (CE),
      .input_byte (input_byte),
      .Data_req   (Data_req),
      .Out_byte   (Out_byte),
      .CEO        (CEO),
      .Valid_out  (Valid_out),
      .Parity_out (Parity_out)
   );

   typedef struct {
      logic [7:0] b;
      logic       par;
      int         slot;
   } exp_t;

   exp_t       sbq[$];
   exp_t       e;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         slot_tb = 0;

   logic [7:0] alog [0:254];
   int         lg   [0:255];
   logic [7:0] genc [0:16];
   logic [7:0] ngen [0:16];
   logic [7:0] msg  [0:187];
   logic [7:0] cw   [0:203];
   logic [7:0] rem  [0:203];
   logic [7:0] got  [0:203];

   logic [7:0] last_ob = 8'h00;
   logic       last_val = 1'b0;
   logic       last_par = 1'b0;

   // Log/antilog multiply, deliberately a different method from the design
   function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return alog[(lg[a] + lg[b]) % 255];
   endfunction

   task automatic build_tables();
      logic [8:0] x;
      x = 9'h001;
      for (int i = 0; i < 255; i++) begin
         alog[i] = x[7:0];
         lg[x[7:0]] = i;
         x = x << 1;
         if (x[8]) x = x ^ 9'h11D;
      end
      for (int j = 0; j <= 16; j++) genc[j] = 8'h00;
      genc[0] = 8'h01;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j <= 16; j++)
            ngen[j] = ((j > 0) ? genc[j-1] : 8'h00) ^ tmul(genc[j], alog[i]);
         for (int j = 0; j <= 16; j++) genc[j] = ngen[j];
      end
   endtask

   // Codeword = message followed by (m(x)*x^16 mod g(x)) by long division
   task automatic encode_model();
      logic [7:0] coef;
      for (int i = 0; i < 188; i++) rem[i] = msg[i];
      for (int i = 188; i < 204; i++) rem[i] = 8'h00;
      for (int i = 0; i < 188; i++) begin
         coef = rem[i];
         rem[i] = 8'h00;
         for (int k = 0; k < 16; k++) rem[i+16-k] = rem[i+16-k] ^ tmul(coef, genc[k]);
      end
      for (int i = 0; i < 188; i++) cw[i] = msg[i];
      for (int i = 188; i < 204; i++) cw[i] = rem[i];
   endtask

   task automatic cycle(input logic ce, input logic [7:0] b);
      @(posedge clk);
      #1;
      CE = ce;
      input_byte = b;
   endtask

   task automatic drive_slot(input int gap);
      for (int g = 0; g < gap; g++) cycle(1'b0, 8'($urandom));
      @(posedge clk);
      #1;
      n_cmp++;
      if (Data_req !== 1'(slot_tb < 188)) begin
         n_bad++;
         $display("FAIL data_req slot %0d: got %b expected %b", slot_tb, Data_req, (slot_tb < 188));
      end
      CE = 1'b1;
      input_byte = (slot_tb < 188) ? cw[slot_tb] : 8'($urandom);
      sbq.push_back('{b: cw[slot_tb], par: (slot_tb >= 188), slot: slot_tb});
      slot_tb = (slot_tb == 203) ? 0 : slot_tb + 1;
   endtask

   task automatic send_block(input int mode, input int gapfix);
      encode_model();
      for (int s = 0; s < 204; s++) drive_slot((mode == 0) ? gapfix : int'($urandom_range(0, 19)));
   endtask

   task automatic drain();
      int budget;
      cycle(1'b0, 8'h00);
      budget = 0;
      while (sbq.size() != 0 && budget < 40) begin
         @(negedge clk);
         budget++;
      end
      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d outputs missing, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic random_msg();
      for (int i = 0; i < 188; i++) msg[i] = 8'($urandom);
   endtask

   // Scoreboard pop on every output strobe, plus hold and reset-quiet checks
   always @(negedge clk) begin
      if (reset) begin
         n_cmp++;
         if (CEO !== 1'b0) begin
            n_bad++;
            $display("FAIL ceo_in_reset: got %b expected 0", CEO);
         end
         last_ob  = 8'h00;
         last_val = 1'b0;
         last_par = 1'b0;
      end else if (CEO === 1'b1) begin
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_ceo: got byte %h expected no strobe", Out_byte);
         end else begin
            e = sbq.pop_front();
            got[e.slot] = Out_byte;
            if (Out_byte !== e.b || Valid_out !== 1'b1 || Parity_out !== e.par) begin
               n_bad++;
               $display("FAIL out slot %0d: got byte %h valid %b par %b expected byte %h valid 1 par %b",
                        e.slot, Out_byte, Valid_out, Parity_out, e.b, e.par);
            end
         end
         last_ob  = Out_byte;
         last_val = Valid_out;
         last_par = Parity_out;
      end else begin
         n_cmp++;
         if (Out_byte !== last_ob || Valid_out !== last_val || Parity_out !== last_par) begin
            n_bad++;
            $display("FAIL hold: got %h/%b/%b expected %h/%b/%b",
                     Out_byte, Valid_out, Parity_out, last_ob, last_val, last_par);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      CE = 1'b0;
      input_byte = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (Out_byte !== 8'h00 || CEO !== 1'b0 || Valid_out !== 1'b0 || Parity_out !== 1'b0 || Data_req !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_state: got ob %h ceo %b val %b par %b req %b expected 00 0 0 0 1",
                  Out_byte, CEO, Valid_out, Parity_out, Data_req);
      end
      reset = 1'b0;
      slot_tb = 0;
   endtask

   task automatic test_all_zero();
      for (int i = 0; i < 188; i++) msg[i] = 8'h00;
      send_block(0, 0);
      drain();
      for (int i = 0; i < 204; i++) begin
         n_cmp++;
         if (got[i] !== 8'h00) begin
            n_bad++;
            $display("FAIL all_zero byte %0d: got %h expected 00", i, got[i]);
         end
      end
   endtask

   task automatic test_impulse();
      for (int i = 0; i < 188; i++) msg[i] = 8'h00;
      msg[187] = 8'h01;
      send_block(0, 0);
      drain();
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (got[188+k] !== genc[15-k]) begin
            n_bad++;
            $display("FAIL impulse g%0d: got %h expected %h", 15 - k, got[188+k], genc[15-k]);
         end
      end
      n_cmp++;
      if (got[188] !== 8'h3B) begin
         n_bad++;
         $display("FAIL impulse g15_const: got %h expected 3b", got[188]);
      end
   endtask

   task automatic test_random_blocks();
      for (int b = 0; b < 10; b++) begin
         random_msg();
         send_block(0, 7);
      end
      drain();
   endtask

   task automatic test_reset_mid_block();
      random_msg();
      send_block(0, 1);
      random_msg();
      encode_model();
      for (int s = 0; s < 100; s++) drive_slot(1);
      drain();
      @(posedge clk);
      #1;
      CE = 1'b1;
      input_byte = 8'hA5;
      #2;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (CEO !== 1'b0 || Data_req !== 1'b1 || Out_byte !== 8'h00) begin
         n_bad++;
         $display("FAIL mid_reset: got ceo %b req %b ob %h expected 0 1 00", CEO, Data_req, Out_byte);
      end
      CE = 1'b0;
      reset = 1'b0;
      slot_tb = 0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (Data_req !== 1'b1 || CEO !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset: got req %b ceo %b expected 1 0", Data_req, CEO);
      end
      random_msg();
      send_block(0, 2);
      drain();
   endtask

   task automatic test_irregular();
      for (int b = 0; b < 3; b++) begin
         random_msg();
         send_block(1, 0);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      random_msg();
      send_block(0, 0);
      random_msg();
      send_block(0, 0);
      drain();
   endtask

   initial begin
      build_tables();
      test_reset();
      test_all_zero();
      test_impulse();
      test_random_blocks();
      test_reset_mid_block();
      test_irregular();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      n_bad++;
      $display("FAIL timeout: run did not complete, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
